// File: rtl/booth_mult_seq.sv
// Sequential signed WIDTH x WIDTH Booth multiplier with a start/done handshake; done follows N+1 edges counting the accepting one.
// start is ignored while busy. Define BOOTH_RADIX4_EN for radix-4 (N=WIDTH/2), otherwise radix-2 (N=WIDTH).
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
  localparam int AW = WIDTH + 2;
  localparam int N  = WIDTH / 2;
`else
  localparam int AW = WIDTH + 1;
  localparam int N  = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH) + 1;

  generate
    if (WIDTH < 2) begin : g_width_min
      $error("booth_mult_seq: WIDTH must be at least 2");
    end
`ifdef BOOTH_RADIX4_EN
    if (WIDTH % 2 != 0) begin : g_width_even
      $error("booth_mult_seq: WIDTH must be even for radix-4");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [AW-1:0]      a_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic               q_m1;
  logic [CNT_W-1:0]   cnt;

  logic [AW-1:0]      m_ext;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      a_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               q_m1_nxt;

  assign m_ext = {{(AW-WIDTH){m_q[WIDTH-1]}}, m_q};

`ifdef BOOTH_RADIX4_EN
  // Triplet recoding: digit in {-2..+2} times M, then shift {A,Q,q_m1} right by 2.
  always_comb begin
    sum = a_q;
    case ({q_q[1:0], q_m1})
      3'b001, 3'b010: sum = a_q + m_ext;
      3'b011:         sum = a_q + (m_ext << 1);
      3'b100:         sum = a_q - (m_ext << 1);
      3'b101, 3'b110: sum = a_q - m_ext;
      default:        sum = a_q;
    endcase
    a_nxt    = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt    = WIDTH'({sum[1:0], q_q} >> 2);
    q_m1_nxt = q_q[1];
  end
`else
  always_comb begin
    sum = a_q;
    case ({q_q[0], q_m1})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
    a_nxt    = {sum[AW-1], sum[AW-1:1]};
    q_nxt    = WIDTH'({sum[0], q_q} >> 1);
    q_m1_nxt = q_q[0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            m_q   <= multiplicand;
            q_q   <= multiplier;
            a_q   <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_W'(N);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q  <= a_nxt;
          q_q  <= q_nxt;
          q_m1 <= q_m1_nxt;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= DONE;
            product <= {a_nxt[WIDTH-1:0], q_nxt};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
